// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame receiver: FSM state encodings
// and parity-mode constants.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational XOR-reduce of a W-bit vector; the same function the
// upstream 3-bit parity generator uses.
module parity_calc #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] vec,
    output logic         par
);

    // Parity of the whole vector
    always_comb begin
        par = ^vec;
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial parity frame receiver: start bit, DATA_W data bits (LSB first),
// parity bit, stop bit. One bit is taken per bit_valid strobe; each frame
// is reported with a one-cycle data_valid pulse.
// Optional feature macro: PARITY_ERR_CNT_EN adds a saturating err_count.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 3,
    parameter bit          ODD    = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam int unsigned  CW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST   = CW'(DATA_W - 1);
    localparam logic         PAR_EXP = ODD ? PAR_ODD : PAR_EVEN;

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("parity_frame_rx: DATA_W and CNT_W must be at least 1");
    end

    state_t              state;
    state_t              state_nx;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   shreg;
    logic                par_pend;
    logic                par_x;

    // Parity of the received data together with the bit on the line; only
    // meaningful while in PARITY, where bit_in is the parity bit.
    parity_calc #(.W(DATA_W + 1)) u_parity_calc (
        .vec ({bit_in, shreg}),
        .par (par_x)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; moves only on accepted bits
    always_comb begin
        state_nx = state;
        if (bit_valid) begin
            case (state)
                IDLE:    if (!bit_in) state_nx = DATA;
                DATA:    if (cnt == LAST) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Bit counter, shift register, pending parity result and frame report
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            shreg      <= '0;
            par_pend   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bit_in) cnt <= '0;
                    end
                    DATA: begin
                        shreg[cnt] <= bit_in;
                        if (cnt != LAST) cnt <= cnt + 1'b1;
                    end
                    PARITY: begin
                        par_pend <= (par_x != PAR_EXP);
                    end
                    STOP: begin
                        data_valid <= 1'b1;
                        data_out   <= shreg;
                        parity_err <= par_pend;
                        frame_err  <= ~bit_in;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // Saturating count of reported frames carrying any error
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (bit_valid && state == STOP && (par_pend || !bit_in)
                     && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

    // Busy whenever a frame is in progress
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (DATA_W=3, even parity, CNT_W=2).
// err_count checks are built only with PARITY_ERR_CNT_EN.
module tb_parity_frame_rx;

    logic       clk;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic [2:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
`ifdef PARITY_ERR_CNT_EN
    logic [1:0] err_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    parity_frame_rx #(
        .DATA_W (3),
        .ODD    (1'b0),
        .CNT_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input logic stp);
        send_bit(1'b0);
        send_bit(d[0]);
        send_bit(d[1]);
        send_bit(d[2]);
        send_bit(p);
        send_bit(stp);
    endtask

    task automatic check_report(input string tag, input logic [2:0] d,
                                input logic pe, input logic fe);
        check({tag, "_valid"}, 32'(data_valid), 32'd1);
        check({tag, "_data"},  32'(data_out),   32'(d));
        check({tag, "_perr"},  32'(parity_err), 32'(pe));
        check({tag, "_ferr"},  32'(frame_err),  32'(fe));
    endtask

    initial begin
        logic [2:0] gap_bits;

        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_data",  32'(data_out),   32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_perr",  32'(parity_err), 32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
`ifdef PARITY_ERR_CNT_EN
        check("rst_cnt",   32'(err_count),  32'd0);
`endif

        // Idle line keeps the FSM in IDLE
        send_bit(1'b1);
        check("idle_busy", 32'(busy), 32'd0);

        // Good frame: 0,1,1,0,0,1 -> 3'b011
        send_bit(1'b0);
        check("good_busy_start", 32'(busy), 32'd1);
        check("good_valid_early", 32'(data_valid), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("good_valid_pre_stop", 32'(data_valid), 32'd0);
        send_bit(1'b1);
        check_report("good", 3'b011, 1'b0, 1'b0);
        check("good_busy_end", 32'(busy), 32'd0);
        tick();
        check("good_valid_pulse", 32'(data_valid), 32'd0);
        check("good_data_hold",   32'(data_out),   32'd3);

        // Parity error: 0,1,0,0,0,1 -> 3'b001
        send_frame(3'b001, 1'b0, 1'b1);
        check_report("perr", 3'b001, 1'b1, 1'b0);
`ifdef PARITY_ERR_CNT_EN
        check("perr_cnt", 32'(err_count), 32'd1);
`endif

        // Framing error: 0,1,1,1,1,0 -> 3'b111, then idle 1
        send_frame(3'b111, 1'b1, 1'b0);
        check_report("ferr", 3'b111, 1'b0, 1'b1);
`ifdef PARITY_ERR_CNT_EN
        check("ferr_cnt", 32'(err_count), 32'd2);
`endif
        send_bit(1'b1);
        check("ferr_idle_busy",  32'(busy),       32'd0);
        check("ferr_idle_valid", 32'(data_valid), 32'd0);
        check("ferr_flag_hold",  32'(frame_err),  32'd1);

        // Gaps of three idle strobes between bits: 3'b101, parity 0
        gap_bits = 3'b101;
        send_bit(1'b0);
        repeat (3) tick();
        check("gap_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            send_bit(gap_bits[i]);
            repeat (3) tick();
        end
        check("gap_busy_data", 32'(busy), 32'd1);
        send_bit(1'b0);
        repeat (3) tick();
        check("gap_busy_par",  32'(busy),       32'd1);
        check("gap_valid_par", 32'(data_valid), 32'd0);
        send_bit(1'b1);
        check_report("gap", 3'b101, 1'b0, 1'b0);
`ifdef PARITY_ERR_CNT_EN
        check("gap_cnt", 32'(err_count), 32'd2);
`endif

        // Reset after two data bits discards the partial frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_data",  32'(data_out),   32'd0);
`ifdef PARITY_ERR_CNT_EN
        check("mid_rst_cnt",   32'(err_count),  32'd0);
`endif
        tick();
        check("mid_rst_valid2", 32'(data_valid), 32'd0);
        send_frame(3'b110, 1'b0, 1'b1);
        check_report("after_rst", 3'b110, 1'b0, 1'b0);

        // Back-to-back: start bit immediately after the stop bit
        send_frame(3'b011, 1'b0, 1'b1);
        check_report("b2b_a", 3'b011, 1'b0, 1'b0);
        send_bit(1'b0);
        check("b2b_busy",  32'(busy),       32'd1);
        check("b2b_valid", 32'(data_valid), 32'd0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check_report("b2b_b", 3'b100, 1'b0, 1'b0);

        // Both errors in one frame
        send_frame(3'b001, 1'b0, 1'b0);
        check_report("both", 3'b001, 1'b1, 1'b1);
`ifdef PARITY_ERR_CNT_EN
        check("both_cnt", 32'(err_count), 32'd1);
`endif

        // rst wins over a start bit in the same cycle
        rst       = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        tick();
        rst       = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        check("rst_prio_busy", 32'(busy),       32'd0);
        check("rst_prio_perr", 32'(parity_err), 32'd0);
        check("rst_prio_ferr", 32'(frame_err),  32'd0);

`ifdef PARITY_ERR_CNT_EN
        // Saturation at 3 with CNT_W=2
        for (int n = 1; n <= 5; n++) begin
            send_frame(3'b001, 1'b0, 1'b1);
            check("sat_cnt", 32'(err_count), (n < 3) ? 32'(n) : 32'd3);
        end
        send_frame(3'b011, 1'b0, 1'b1);
        check("sat_cnt_good", 32'(err_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_cnt_rst", 32'(err_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
